// File: rtl/ysyx_24100012_lsu_pkg.sv
// Shared types and constants for the NPC load/store unit.
package ysyx_24100012_lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_N = 4;

    // funct3 encodings for loads and stores
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Byte-lane strobes before shifting to the addressed lane
    localparam logic [STRB_N-1:0] STRB_NONE = 4'b0000;
    localparam logic [STRB_N-1:0] STRB_B    = 4'b0001;
    localparam logic [STRB_N-1:0] STRB_H    = 4'b0011;
    localparam logic [STRB_N-1:0] STRB_W    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // Data-memory request payload, held stable while the request is pending
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [XLEN-1:0]   wdata;
        logic [STRB_N-1:0] wstrb;
    } lsu_req_t;

    // True when {is_store, funct3} names a supported load or store
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
        end
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

endpackage

// File: rtl/ysyx_24100012_lsu_align.sv
// Byte-lane steering for the LSU: store strobes/data, load extraction and
// extension, op legality and misalignment detection.
// LSU_MISALIGN_TRAP_EN: report misaligned h/w accesses; when undefined the
// offending low address bits are cleared and the access proceeds.
module ysyx_24100012_lsu_align
    import ysyx_24100012_lsu_pkg::*;
(
    input  logic [3:0]        i_op,
    input  logic [1:0]        i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN-1:0]   i_rdata,
    output logic [STRB_N-1:0] o_wstrb,
    output logic [XLEN-1:0]   o_wdata,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_legal,
    output logic              o_misalign
);

    logic            w_store;
    logic [2:0]      w_f3;
    logic [1:0]      w_off;
    logic [XLEN-1:0] w_rword;

    // Legality, alignment and effective lane offset
    always_comb begin
        w_store    = i_op[3];
        w_f3       = i_op[2:0];
        o_legal    = f3_legal(w_store, w_f3);
        o_misalign = 1'b0;
        w_off      = i_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        o_misalign = o_legal &&
                     (((w_f3[1:0] == 2'b01) && i_addr[0]) ||
                      ((w_f3[1:0] == 2'b10) && (i_addr != 2'b00)));
`else
        case (w_f3[1:0])
            2'b01:   w_off = {i_addr[1], 1'b0};
            2'b10:   w_off = 2'b00;
            default: w_off = i_addr;
        endcase
`endif
    end

    // Store strobes and lane-replicated write data
    always_comb begin
        o_wstrb = STRB_NONE;
        o_wdata = i_wdata;
        if (w_store && o_legal) begin
            case (w_f3[1:0])
                2'b00: begin
                    o_wstrb = STRB_B << w_off;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                2'b01: begin
                    o_wstrb = STRB_H << w_off;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                default: begin
                    o_wstrb = STRB_W;
                    o_wdata = i_wdata;
                end
            endcase
        end
    end

    // Load extraction from the addressed lane with sign/zero extension
    always_comb begin
        w_rword = i_rdata >> {w_off, 3'b000};
        case (w_f3)
            LB:      o_rdata = {{24{w_rword[7]}}, w_rword[7:0]};
            LH:      o_rdata = {{16{w_rword[15]}}, w_rword[15:0]};
            LBU:     o_rdata = {24'h000000, w_rword[7:0]};
            LHU:     o_rdata = {16'h0000, w_rword[15:0]};
            default: o_rdata = w_rword;
        endcase
    end

endmodule

// File: rtl/ysyx_24100012_lsu.sv
// Load/store unit: one data-memory transaction per op, result to writeback.
// LSU_MISALIGN_TRAP_EN: misaligned h/w accesses fault without a bus request.
module ysyx_24100012_lsu
    import ysyx_24100012_lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    input  logic [3:0]            in_op,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]            mem_req_wstrb,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    input  logic                  mem_resp_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic                  out_err,
    output logic                  out_misalign
);

    lsu_state_e r_state;
    lsu_state_e w_state_nxt;

    logic r_in_ready;
    logic r_req_valid;
    logic r_resp_ready;
    logic r_out_valid;
    logic w_in_ready_nxt;
    logic w_req_valid_nxt;
    logic w_resp_ready_nxt;
    logic w_out_valid_nxt;

    lsu_req_t        r_req;
    logic [3:0]      r_op;
    logic [1:0]      r_addr_lo;
    logic [XLEN-1:0] r_out_rdata;
    logic            r_out_err;
    logic            r_out_misalign;

    logic              w_idle;
    logic              w_accept;
    logic              w_fault;
    logic              w_fault_mis;
    logic              w_resp_fire;
    logic [3:0]        w_op_sel;
    logic [1:0]        w_addr_sel;
    logic [STRB_N-1:0] w_wstrb;
    logic [XLEN-1:0]   w_wdata_sh;
    logic [XLEN-1:0]   w_rdata_ext;
    logic              w_legal;
    logic              w_misalign;

    assign w_idle      = (r_state == IDLE);
    assign w_accept    = w_idle && in_valid;
    assign w_resp_fire = (r_state == WAIT) && mem_resp_valid;
    assign w_fault     = ~w_legal | w_misalign;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_fault_mis = 1'b1;
`else
    assign w_fault_mis = 1'b0;
`endif

    // Incoming op steers lanes at accept; the latched op steers load extraction
    assign w_op_sel   = w_idle ? in_op : r_op;
    assign w_addr_sel = w_idle ? in_addr[1:0] : r_addr_lo;

    ysyx_24100012_lsu_align u_align (
        .i_op       (w_op_sel),
        .i_addr     (w_addr_sel),
        .i_wdata    (in_wdata),
        .i_rdata    (mem_resp_rdata),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_rdata_ext),
        .o_legal    (w_legal),
        .o_misalign (w_misalign)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (in_valid)       w_state_nxt = w_fault ? DONE : REQ;
            REQ:  if (mem_req_ready)  w_state_nxt = WAIT;
            WAIT: if (mem_resp_valid) w_state_nxt = DONE;
            DONE: if (out_ready)      w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the upcoming state
    always_comb begin
        w_in_ready_nxt   = 1'b0;
        w_req_valid_nxt  = 1'b0;
        w_resp_ready_nxt = 1'b0;
        w_out_valid_nxt  = 1'b0;
        case (w_state_nxt)
            IDLE:    w_in_ready_nxt   = 1'b1;
            REQ:     w_req_valid_nxt  = 1'b1;
            WAIT:    w_resp_ready_nxt = 1'b1;
            DONE:    w_out_valid_nxt  = 1'b1;
            default: w_in_ready_nxt   = 1'b1;
        endcase
    end

    // Registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready   <= 1'b1;
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_in_ready   <= w_in_ready_nxt;
            r_req_valid  <= w_req_valid_nxt;
            r_resp_ready <= w_resp_ready_nxt;
            r_out_valid  <= w_out_valid_nxt;
        end
    end

    // Op latch, bus request payload and writeback result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op           <= 4'h0;
            r_addr_lo      <= 2'b00;
            r_req          <= '0;
            r_out_rdata    <= '0;
            r_out_err      <= 1'b0;
            r_out_misalign <= 1'b0;
        end else if (w_accept) begin
            r_op        <= in_op;
            r_addr_lo   <= in_addr[1:0];
            r_req.addr  <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
            r_req.wen   <= in_op[3];
            r_req.wdata <= w_wdata_sh;
            r_req.wstrb <= w_wstrb;
            if (w_fault) begin
                r_out_rdata    <= '0;
                r_out_err      <= 1'b1;
                r_out_misalign <= w_fault_mis;
            end
        end else if (w_resp_fire) begin
            r_out_rdata    <= (mem_resp_err || r_op[3]) ? '0 : w_rdata_ext;
            r_out_err      <= mem_resp_err;
            r_out_misalign <= 1'b0;
        end
    end

    assign in_ready       = r_in_ready;
    assign mem_req_valid  = r_req_valid;
    assign mem_req_addr   = r_req.addr;
    assign mem_req_wen    = r_req.wen;
    assign mem_req_wdata  = r_req.wdata;
    assign mem_req_wstrb  = r_req.wstrb;
    assign mem_resp_ready = r_resp_ready;
    assign out_valid      = r_out_valid;
    assign out_rdata      = r_out_rdata;
    assign out_err        = r_out_err;
    assign out_misalign   = r_out_misalign;

endmodule

// File: tb/tb_ysyx_24100012_lsu.sv
// Directed self-checking bench for ysyx_24100012_lsu.
// Expectations for misaligned accesses follow LSU_MISALIGN_TRAP_EN.
module tb_ysyx_24100012_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [3:0]  in_op;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        out_misalign;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    ysyx_24100012_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_op          (in_op),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_err   (mem_resp_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rdata      (out_rdata),
        .out_err        (out_err),
        .out_misalign   (out_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete op from accept to writeback handshake; starts in IDLE, #1 after an edge
    task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input logic resp_err,
                          input int req_stall, input int out_stall, input logic exp_bus,
                          input logic [31:0] exp_addr, input logic [3:0] exp_wstrb,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input logic exp_mis);
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = addr;
        in_wdata = wdata;
        check({nm, " in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        if (exp_bus) begin
            check({nm, " req_valid"}, 32'(mem_req_valid), 32'd1);
            check({nm, " req_addr"}, mem_req_addr, exp_addr);
            check({nm, " req_wen"}, 32'(mem_req_wen), 32'(op[3]));
            check({nm, " req_wstrb"}, 32'(mem_req_wstrb), 32'(exp_wstrb));
            if (op[3]) check({nm, " req_wdata"}, mem_req_wdata, exp_wdata);
            for (int i = 0; i < req_stall; i++) begin
                step();
                check({nm, " stall req_valid"}, 32'(mem_req_valid), 32'd1);
                check({nm, " stall req_addr"}, mem_req_addr, exp_addr);
                check({nm, " stall req_wstrb"}, 32'(mem_req_wstrb), 32'(exp_wstrb));
                check({nm, " stall in_ready"}, 32'(in_ready), 32'd0);
            end
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
            check({nm, " req_valid drop"}, 32'(mem_req_valid), 32'd0);
            check({nm, " resp_ready"}, 32'(mem_resp_ready), 32'd1);
            mem_resp_valid = 1'b1;
            mem_resp_rdata = rdata;
            mem_resp_err   = resp_err;
            step();
            mem_resp_valid = 1'b0;
            mem_resp_err   = 1'b0;
        end else begin
            check({nm, " no req_valid"}, 32'(mem_req_valid), 32'd0);
        end
        check({nm, " out_valid"}, 32'(out_valid), 32'd1);
        check({nm, " out_rdata"}, out_rdata, exp_rdata);
        check({nm, " out_err"}, 32'(out_err), 32'(exp_err));
        check({nm, " out_misalign"}, 32'(out_misalign), 32'(exp_mis));
        for (int i = 0; i < out_stall; i++) begin
            step();
            check({nm, " hold out_valid"}, 32'(out_valid), 32'd1);
            check({nm, " hold out_rdata"}, out_rdata, exp_rdata);
            check({nm, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({nm, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({nm, " back idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst            = 1'b0;
        in_valid       = 1'b0;
        in_addr        = '0;
        in_wdata       = '0;
        in_op          = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        mem_resp_err   = 1'b0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst req_valid", 32'(mem_req_valid), 32'd0);
        check("rst resp_ready", 32'(mem_resp_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst req_wstrb", 32'(mem_req_wstrb), 32'd0);
        check("rst out_rdata", out_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        //     name    op       addr          wdata         rdata         err  rs os bus addr          strb     wdata         rdata         err  mis
        run_op("lw",   4'b0010, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 1'b0, 0, 0, 1'b1, 32'h8000_0004, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0);
        run_op("lb",   4'b0000, 32'h8000_0003, 32'h0,        32'h80FF_1234, 1'b0, 0, 0, 1'b1, 32'h8000_0000, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0);
        run_op("lbu",  4'b0100, 32'h8000_0003, 32'h0,        32'h80FF_1234, 1'b0, 0, 0, 1'b1, 32'h8000_0000, 4'b0000, 32'h0,        32'h0000_0080, 1'b0, 1'b0);
        run_op("sh",   4'b1001, 32'h8000_0002, 32'h1234_ABCD, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b1, 32'h8000_0000, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0, 1'b0);
        run_op("sb",   4'b1000, 32'h8000_0001, 32'h0000_00A5, 32'h1111_1111, 1'b0, 0, 0, 1'b1, 32'h8000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0);
        run_op("sw",   4'b1010, 32'h8000_0008, 32'hCAFE_F00D, 32'h0,        1'b0, 0, 0, 1'b1, 32'h8000_0008, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b0);
        run_op("lh",   4'b0001, 32'h8000_0002, 32'h0,        32'hBEEF_0000, 1'b0, 0, 0, 1'b1, 32'h8000_0000, 4'b0000, 32'h0,        32'hFFFF_BEEF, 1'b0, 1'b0);
        run_op("lhu",  4'b0101, 32'h8000_0002, 32'h0,        32'hBEEF_0000, 1'b0, 0, 0, 1'b1, 32'h8000_0000, 4'b0000, 32'h0,        32'h0000_BEEF, 1'b0, 1'b0);
        if (TRAP) begin
            run_op("lw mis", 4'b0010, 32'h8000_0002, 32'h0, 32'h1122_3344, 1'b0, 0, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
            run_op("sh mis", 4'b1001, 32'h8000_0003, 32'h0000_BEEF, 32'h0, 1'b0, 0, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
        end else begin
            run_op("lw mis", 4'b0010, 32'h8000_0002, 32'h0, 32'h1122_3344, 1'b0, 0, 0, 1'b1, 32'h8000_0000, 4'b0000, 32'h0, 32'h1122_3344, 1'b0, 1'b0);
            run_op("sh mis", 4'b1001, 32'h8000_0003, 32'h0000_BEEF, 32'h0, 1'b0, 0, 0, 1'b1, 32'h8000_0000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 1'b0);
        end
        run_op("ld ill", 4'b0011, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, TRAP);
        run_op("st ill", 4'b1100, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, TRAP);
        run_op("buserr", 4'b0010, 32'h8000_0010, 32'h0, 32'h5555_5555, 1'b1, 5, 0, 1'b1, 32'h8000_0010, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0);
        run_op("wbstall", 4'b0010, 32'h8000_0014, 32'h0, 32'h0BAD_F00D, 1'b0, 0, 3, 1'b1, 32'h8000_0014, 4'b0000, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0);

        // Drop an op with reset while it waits for its response
        in_valid = 1'b1;
        in_op    = 4'b0010;
        in_addr  = 32'h8000_0020;
        step();
        in_valid      = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("midrst resp_ready", 32'(mem_resp_ready), 32'd1);
        rst = 1'b0;
        #2;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst req_valid", 32'(mem_req_valid), 32'd0);
        check("midrst resp_ready off", 32'(mem_resp_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("postrst in_ready", 32'(in_ready), 32'd1);
        check("postrst out_valid", 32'(out_valid), 32'd0);
        run_op("postrst lw", 4'b0010, 32'h8000_0018, 32'h0, 32'h1234_5678, 1'b0, 0, 0, 1'b1, 32'h8000_0018, 4'b0000, 32'h0, 32'h1234_5678, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_24100012_lsu.md
Name: ysyx_24100012_lsu

Overview:
- Load/store unit directly downstream of the ALU in the NPC execute path.
- Takes the ALU result as the effective address, plus rs2 data and the memory op.
- Performs one request/response transaction on the data-memory bus, with byte-lane alignment and sign/zero extension.
- Returns the load result or store completion to writeback over a valid/ready handshake; one transaction in flight at a time.

Parameters:
DATA_WIDTH, 32, data and bus word width; only 32 supported
ADDR_WIDTH, 32, address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
in_valid  in  1  op presented by execute
in_ready  out  1  LSU can accept an op
in_addr  in  ADDR_WIDTH  effective address (ALU out)
in_wdata  in  DATA_WIDTH  store data (x[rs2])
in_op  in  4  {is_store, funct3}
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_req_addr  out  ADDR_WIDTH  word-aligned address {in_addr[31:2],2'b00}
mem_req_wen  out  1  1=write
mem_req_wdata  out  DATA_WIDTH  lane-shifted store data
mem_req_wstrb  out  4  byte enables (0 on reads)
mem_resp_valid  in  1  bus response valid
mem_resp_ready  out  1  LSU accepts response
mem_resp_rdata  in  DATA_WIDTH  read word
mem_resp_err  in  1  bus error
out_valid  out  1  result to writeback
out_ready  in  1  writeback accepts
out_rdata  out  DATA_WIDTH  extended load data; 0 for stores
out_err  out  1  access fault or misalignment
out_misalign  out  1  error caused by misalignment or illegal funct3

Behaviour:
- Reset (rst low, async): state=IDLE. All outputs 0 except in_ready=1. Latched op/addr/data cleared.
- Reset mid-transaction: returns to IDLE and drops the op. The bus must not deliver a response for a dropped request.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. When in_valid, latch addr/wdata/op.
  - Legal op: go to REQ.
  - Misaligned/illegal op: go to DONE with out_err=1 and out_misalign=1; no bus request is issued.
- REQ: mem_req_valid=1, with request fields held stable until mem_req_ready. On handshake, go to WAIT.
- WAIT: mem_resp_ready=1. On mem_resp_valid, latch extended data and err=mem_resp_err, then go to DONE.
  - A response in the same cycle as the request handshake is not legal.
- DONE: out_valid=1, outputs held stable until out_ready, then go to IDLE. in_ready=0 outside IDLE, so no back-to-back overlap.
- Minimum latency: accept at cycle 0, request at cycle 1, response at cycle 2, out_valid at cycle 3.
- Legal ops:
  - Loads: funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Anything else is illegal.
- Alignment: h needs addr[0]=0; w needs addr[1:0]=0.
- Store lanes:
  - sb: wstrb=4'b0001<<addr[1:0], wdata={4{byte}}.
  - sh: wstrb=4'b0011<<addr[1:0], wdata={2{half}}.
  - sw: wstrb=4'hF, wdata=in_wdata.
- Load extract: word = rdata>>(addr[1:0]*8); lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
- Bus error: out_err=1, out_misalign=0, out_rdata=0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses fault as described above.
- Undefined: misalignment is not checked. addr[0] is cleared for h and addr[1:0] for w before lane selection, the access proceeds, and out_misalign is tied 0. Illegal funct3 still faults.

Decomposition:
- Package ysyx_24100012_lsu_pkg holds:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - state enum (IDLE, REQ, WAIT, DONE);
  - strobe constants.
- One combinational sub-module, ysyx_24100012_lsu_align. It takes op and addr[1:0] and produces wstrb, shifted wdata, extracted/extended rdata and the legal/misalign flags.

Test Plan:
- lw addr=0x8000_0004, mem returns 0xDEAD_BEEF after 1 cycle → mem_req_addr=0x8000_0004, wstrb=0, out_rdata=0xDEAD_BEEF, out_valid at cycle 3.
- lb addr=0x8000_0003, rdata=0x80FF_1234 → out_rdata=0xFFFF_FF80; same with lbu → 0x0000_0080.
- sh addr=0x8000_0002, wdata=0x1234_ABCD → mem_req_wstrb=4'b1100, mem_req_wdata=0xABCD_ABCD, out_rdata=0.
- lw addr=0x8000_0002 with LSU_MISALIGN_TRAP_EN → no mem_req_valid, out_err=1, out_misalign=1. Without the macro → request to 0x8000_0000, normal load.
- mem_req_ready held low 5 cycles, then mem_resp_err=1 → request fields stable throughout, in_ready=0, out_err=1, out_misalign=0.
- out_ready low 3 cycles in DONE, then rst pulsed low mid-WAIT on the next op → out held stable; after reset in_ready=1, out_valid=0, mem_req_valid=0.
